// File: rtl/cp0_ext.sv
// cp0_ext: coprocessor-0 subset with Count/Compare timer,
// interrupt capture, exception commit and MFC0/MTC0 access.
module cp0_ext #(
  parameter int          HW_INT_N      = 6,
  parameter int          COUNT_DIV     = 2,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [HW_INT_N-1:0] INT_EDGE_MASK = {HW_INT_N{1'b0}},
  parameter logic [31:0] PRID          = 32'h0000_4220,
  parameter logic [31:0] CONFIG        = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HW_INT_N-1:0] ext_int,
  input  logic                wen,
  input  logic [7:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic                exc_valid,
  input  logic [4:0]          exc_excode,
  input  logic                exc_bd,
  input  logic [31:0]         exc_epc,
  input  logic [31:0]         exc_badvaddr,
  input  logic                exc_eret,
  output logic                int_req,
  output logic [31:0]         status,
  output logic [31:0]         cause,
  output logic [31:0]         epc
);

  localparam logic [7:0] A_BADV = 8'h40;
  localparam logic [7:0] A_CNT  = 8'h48;
  localparam logic [7:0] A_CMP  = 8'h58;
  localparam logic [7:0] A_ST   = 8'h60;
  localparam logic [7:0] A_CA   = 8'h68;
  localparam logic [7:0] A_EPC  = 8'h70;
  localparam logic [7:0] A_PRID = 8'h78;
  localparam logic [7:0] A_CFG  = 8'h80;

  logic we_cnt, we_cmp, we_st, we_ca, we_epc;
  logic exc_take, exc_ret, exc_first;

  logic        bev, exl, ie;
  logic [7:0]  im;
  logic        bd, ti;
  logic [1:0]  ip_sw;
  logic [4:0]  excode;
  logic [31:0] epc_q, badv;
  logic [31:0] count, compare;
  logic [3:0]  presc;
  logic        tick, ti_hit;

  logic [HW_INT_N-1:0] s_out, s_prev, ip_hw;
  logic [5:0]          hw6;
  logic [7:0]          ip;

  assign we_cnt = wen && (addr == A_CNT);
  assign we_cmp = wen && (addr == A_CMP);
  assign we_st  = wen && (addr == A_ST);
  assign we_ca  = wen && (addr == A_CA);
  assign we_epc = wen && (addr == A_EPC);

  assign exc_take  = exc_valid & ~exc_eret;
  assign exc_ret   = exc_valid & exc_eret;
  assign exc_first = exc_take & ~exl;

  // Input synchronisers, optional per SYNC_STAGES
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_out = ext_int;
  end else begin : g_sync
    logic [HW_INT_N-1:0] q [SYNC_STAGES];
    // Shift external lines through the flop chain
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < SYNC_STAGES; k++)
          q[k] <= '0;
      end else begin
        q[0] <= ext_int;
        for (int k = 1; k < SYNC_STAGES; k++)
          q[k] <= q[k-1];
      end
    end
    assign s_out = q[SYNC_STAGES-1];
  end

  // Hardware IP bits: level follow, or edge latch held until cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_prev <= '0;
      ip_hw  <= '0;
    end else begin
      s_prev <= s_out;
      for (int i = 0; i < HW_INT_N; i++) begin
        if (INT_EDGE_MASK[i]) begin
          if (s_out[i] && !s_prev[i])
            ip_hw[i] <= 1'b1;
          else if (we_ca && !wdata[10+i])
            ip_hw[i] <= 1'b0;
        end else begin
          ip_hw[i] <= s_out[i];
        end
      end
    end
  end

  assign tick = (presc == 4'(COUNT_DIV - 1));

  // Count prescaler and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      count <= '0;
    end else if (we_cnt) begin
      presc <= '0;
      count <= wdata;
    end else if (tick) begin
      presc <= '0;
      count <= count + 32'd1;
    end else begin
      presc <= presc + 4'd1;
    end
  end

  assign ti_hit = tick && !we_cnt && ((count + 32'd1) == compare);

  // Compare register and timer interrupt flag; a write clears TI
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare <= '0;
      ti      <= 1'b0;
    end else if (we_cmp) begin
      compare <= wdata;
      ti      <= 1'b0;
    end else if (ti_hit) begin
      ti <= 1'b1;
    end
  end

  // Status fields; exception commit owns EXL over MTC0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bev <= 1'b1;
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (we_st) begin
        bev <= wdata[22];
        im  <= wdata[15:8];
        ie  <= wdata[0];
      end
      if (exc_take)
        exl <= 1'b1;
      else if (exc_ret)
        exl <= 1'b0;
      else if (we_st)
        exl <= wdata[1];
    end
  end

  // Exception state: EPC/BD/ExcCode on first entry, BadVAddr on AdE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc_q  <= '0;
      bd     <= 1'b0;
      excode <= '0;
      badv   <= '0;
      ip_sw  <= '0;
    end else begin
      if (exc_first) begin
        epc_q  <= exc_epc;
        bd     <= exc_bd;
        excode <= exc_excode;
      end else if (we_epc && !exc_valid) begin
        epc_q <= wdata;
      end
      if (exc_take &&
          (exc_excode == 5'h04 || exc_excode == 5'h05))
        badv <= exc_badvaddr;
      if (we_ca)
        ip_sw <= wdata[9:8];
    end
  end

  // Widen hardware lines to six so IP[7] merge is uniform
  always_comb begin
    hw6 = '0;
    hw6[HW_INT_N-1:0] = ip_hw;
  end

  assign ip = {ti | hw6[5], hw6[4:0], ip_sw};

  assign status = {9'b0, bev, 6'b0, im, 6'b0, exl, ie};
  assign cause  = {bd, ti, 14'b0, ip, 1'b0, excode, 2'b0};
  assign epc    = epc_q;

  assign int_req = (|(ip & im)) & ie & ~exl;

  // MFC0 read mux
  always_comb begin
    rdata = '0;
    unique case (addr)
      A_BADV:  rdata = badv;
      A_CNT:   rdata = count;
      A_CMP:   rdata = compare;
      A_ST:    rdata = status;
      A_CA:    rdata = cause;
      A_EPC:   rdata = epc_q;
      A_PRID:  rdata = PRID;
      A_CFG:   rdata = CONFIG;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ext.sv
// tb_cp0_ext: directed and random checks of cp0_ext
// against a cycle-level behavioural model.
module tb_cp0_ext;

  localparam int HW   = 6;
  localparam int DIV  = 2;
  localparam int SYNC = 2;
  localparam logic [5:0] EDGE = 6'b000011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  ext_int = '0;
  logic        wen = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_excode = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_epc = '0;
  logic [31:0] exc_badvaddr = '0;
  logic        exc_eret = 1'b0;
  logic        int_req;
  logic [31:0] status, cause, epc;

  int errors = 0;
  int checks = 0;

  cp0_ext #(
    .HW_INT_N(HW), .COUNT_DIV(DIV),
    .SYNC_STAGES(SYNC), .INT_EDGE_MASK(EDGE)
  ) dut (
    .clk(clk), .reset(reset), .ext_int(ext_int),
    .wen(wen), .addr(addr), .wdata(wdata),
    .rdata(rdata), .exc_valid(exc_valid),
    .exc_excode(exc_excode), .exc_bd(exc_bd),
    .exc_epc(exc_epc), .exc_badvaddr(exc_badvaddr),
    .exc_eret(exc_eret), .int_req(int_req),
    .status(status), .cause(cause), .epc(epc)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_bev, m_exl, m_ie, m_bd, m_ti;
  logic [7:0]  m_im;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bad, m_cmp, m_base;
  int unsigned m_ticks;
  logic [5:0]  m_hw;
  logic [5:0]  m_hist [0:SYNC+1];

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_ticks / DIV);
  endfunction

  task automatic model_reset();
    m_bev = 1'b1; m_exl = 1'b0; m_ie = 1'b0;
    m_bd = 1'b0; m_ti = 1'b0; m_im = '0;
    m_sw = '0; m_code = '0; m_epc = '0;
    m_bad = '0; m_cmp = '0; m_base = '0;
    m_ticks = 0; m_hw = '0;
    for (int k = 0; k <= SYNC + 1; k++)
      m_hist[k] = '0;
  endtask

  task automatic model_step();
    logic [31:0] c0, c1;
    logic hit, exl0, take, ret;
    logic w_cnt, w_cmp, w_st, w_ca, w_epc;
    logic [5:0] cur, prv;
    w_cnt = wen && addr == 8'h48;
    w_cmp = wen && addr == 8'h58;
    w_st  = wen && addr == 8'h60;
    w_ca  = wen && addr == 8'h68;
    w_epc = wen && addr == 8'h70;
    take = exc_valid && !exc_eret;
    ret  = exc_valid && exc_eret;
    exl0 = m_exl;
    for (int k = SYNC + 1; k > 0; k--)
      m_hist[k] = m_hist[k-1];
    m_hist[0] = ext_int;
    cur = m_hist[SYNC];
    prv = m_hist[SYNC+1];
    hit = 1'b0;
    if (w_cnt) begin
      m_base = wdata; m_ticks = 0;
    end else begin
      c0 = m_count();
      m_ticks++;
      c1 = m_count();
      hit = (c1 != c0) && (c1 == m_cmp);
    end
    if (w_cmp) begin
      m_cmp = wdata; m_ti = 1'b0;
    end else if (hit) begin
      m_ti = 1'b1;
    end
    if (w_st) begin
      m_bev = wdata[22];
      m_im  = wdata[15:8];
      m_ie  = wdata[0];
      if (!exc_valid) m_exl = wdata[1];
    end
    if (w_ca) m_sw = wdata[9:8];
    for (int i = 0; i < 6; i++) begin
      if (EDGE[i]) begin
        if (cur[i] && !prv[i]) m_hw[i] = 1'b1;
        else if (w_ca && !wdata[10+i]) m_hw[i] = 1'b0;
      end else begin
        m_hw[i] = cur[i];
      end
    end
    if (w_epc && !exc_valid) m_epc = wdata;
    if (take) begin
      if (!exl0) begin
        m_epc = exc_epc; m_bd = exc_bd; m_code = exc_excode;
      end
      m_exl = 1'b1;
      if (exc_excode == 5'h04 || exc_excode == 5'h05)
        m_bad = exc_badvaddr;
    end else if (ret) begin
      m_exl = 1'b0;
    end
  endtask

  function automatic logic [7:0] e_ip();
    return {m_ti | m_hw[5], m_hw[4:0], m_sw};
  endfunction

  function automatic logic [31:0] e_status();
    return {9'b0, m_bev, 6'b0, m_im, 6'b0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] e_cause();
    return {m_bd, m_ti, 14'b0, e_ip(), 1'b0, m_code, 2'b0};
  endfunction

  function automatic logic e_int();
    return (|(e_ip() & m_im)) & m_ie & ~m_exl;
  endfunction

  function automatic logic [31:0] e_rd(input logic [7:0] a);
    case (a)
      8'h40: return m_bad;
      8'h48: return m_count();
      8'h58: return m_cmp;
      8'h60: return e_status();
      8'h68: return e_cause();
      8'h70: return m_epc;
      8'h78: return 32'h0000_4220;
      8'h80: return 32'h8000_0000;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) if (!reset) model_step();

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; exc_valid = 1'b0; exc_eret = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wen = 1'b1; addr = a; wdata = d;
    cyc();
    wen = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    idle();
    cyc(); cyc();
    checks++;
    if (status !== 32'h0040_0000) begin
      errors++; $display("FAIL rst_status got=%h exp=%h", status, 32'h0040_0000);
    end
    checks++;
    if (cause !== 32'h0) begin
      errors++; $display("FAIL rst_cause got=%h exp=0", cause);
    end
    checks++;
    if (epc !== 32'h0 || int_req !== 1'b0) begin
      errors++; $display("FAIL rst_epc_int got=%h/%b exp=0/0", epc, int_req);
    end
    addr = 8'h78; #1;
    checks++;
    if (rdata !== 32'h0000_4220) begin
      errors++; $display("FAIL prid got=%h exp=%h", rdata, 32'h0000_4220);
    end
    reset = 1'b0;
  endtask

  task automatic test_timer();
    int k;
    wr(8'h48, 32'd5);
    wen = 1'b1; addr = 8'h58; wdata = 32'd8;
    k = 0;
    do begin
      cyc(); wen = 1'b0; k++;
    end while (!cause[30] && k < 20);
    checks++;
    if (k != 6) begin
      errors++; $display("FAIL ti_latency got=%0d exp=6", k);
    end
    addr = 8'h48; #1;
    checks++;
    if (rdata !== 32'd8) begin
      errors++; $display("FAIL ti_count got=%h exp=8", rdata);
    end
    checks++;
    if (cause !== e_cause()) begin
      errors++; $display("FAIL ti_cause got=%h exp=%h", cause, e_cause());
    end
    wr(8'h58, 32'h1000);
    checks++;
    if (cause[30] !== 1'b0) begin
      errors++; $display("FAIL ti_clear got=%b exp=0", cause[30]);
    end
  endtask

  task automatic test_edge_int();
    wr(8'h60, 32'h0000_0401);
    ext_int[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      ext_int[0] = 1'b0;
      checks++;
      if (int_req !== (k >= SYNC + 1)) begin
        errors++;
        $display("FAIL edge_int k=%0d got=%b exp=%b", k, int_req, k >= SYNC + 1);
      end
    end
    wr(8'h68, 32'h0);
    checks++;
    if (int_req !== 1'b0 || cause[10] !== 1'b0) begin
      errors++; $display("FAIL edge_clear got=%b/%b exp=0/0", int_req, cause[10]);
    end
  endtask

  task automatic test_exception();
    exc_valid = 1'b1; exc_eret = 1'b0; exc_bd = 1'b0;
    exc_excode = 5'h04; exc_epc = 32'hBFC0_0100;
    exc_badvaddr = 32'h0000_0003; addr = 8'h40;
    cyc();
    idle();
    checks++;
    if (status[1] !== 1'b1 || epc !== 32'hBFC0_0100) begin
      errors++; $display("FAIL exc_entry got=%b/%h exp=1/bfc00100", status[1], epc);
    end
    checks++;
    if (cause[6:2] !== 5'h04 || rdata !== 32'h3) begin
      errors++; $display("FAIL exc_code_bad got=%h/%h exp=04/3", cause[6:2], rdata);
    end
    exc_valid = 1'b1; exc_excode = 5'h0C;
    exc_epc = 32'h8000_0180; exc_badvaddr = 32'h1234;
    cyc();
    idle();
    checks++;
    if (epc !== 32'hBFC0_0100 || cause[6:2] !== 5'h04) begin
      errors++; $display("FAIL exc_nested got=%h/%h exp=bfc00100/04", epc, cause[6:2]);
    end
    checks++;
    if (rdata !== 32'h3 || status[1] !== 1'b1) begin
      errors++; $display("FAIL exc_nested_bad got=%h/%b exp=3/1", rdata, status[1]);
    end
  endtask

  task automatic test_eret();
    wr(8'h60, 32'h0000_1403);
    ext_int[2] = 1'b1;
    repeat (4) cyc();
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL eret_masked got=%b exp=0", int_req);
    end
    exc_valid = 1'b1; exc_eret = 1'b1;
    cyc();
    idle();
    checks++;
    if (status[1] !== 1'b0 || int_req !== 1'b1) begin
      errors++; $display("FAIL eret got=%b/%b exp=0/1", status[1], int_req);
    end
    checks++;
    if (epc !== 32'hBFC0_0100) begin
      errors++; $display("FAIL eret_epc got=%h exp=bfc00100", epc);
    end
    ext_int[2] = 1'b0;
  endtask

  task automatic test_same_cycle();
    wen = 1'b1; addr = 8'h60; wdata = 32'h0;
    exc_valid = 1'b1; exc_eret = 1'b0;
    exc_excode = 5'h08; exc_epc = 32'h0000_0444;
    cyc();
    idle();
    checks++;
    if (status[1:0] !== 2'b10 || epc !== 32'h444) begin
      errors++; $display("FAIL same_st got=%b/%h exp=10/444", status[1:0], epc);
    end
    wen = 1'b1; addr = 8'h70; wdata = 32'hDEAD;
    exc_valid = 1'b1; exc_excode = 5'h0A;
    cyc();
    idle();
    checks++;
    if (epc !== 32'h444) begin
      errors++; $display("FAIL same_epc got=%h exp=444", epc);
    end
    exc_valid = 1'b1; exc_eret = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_read_old();
    wen = 1'b1; addr = 8'h58; wdata = 32'h55;
    #1;
    checks++;
    if (rdata !== 32'h1000) begin
      errors++; $display("FAIL read_old got=%h exp=1000", rdata);
    end
    cyc();
    wen = 1'b0;
    checks++;
    if (rdata !== 32'h55) begin
      errors++; $display("FAIL read_new got=%h exp=55", rdata);
    end
    wr(8'h44, 32'hFFFF_FFFF);
    addr = 8'h44; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL unmapped got=%h exp=0", rdata);
    end
    addr = 8'h80; #1;
    checks++;
    if (rdata !== 32'h8000_0000) begin
      errors++; $display("FAIL config got=%h exp=80000000", rdata);
    end
  endtask

  task automatic test_random();
    logic [7:0] alist [9];
    alist = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68,
              8'h70, 8'h78, 8'h80, 8'h10};
    for (int n = 0; n < 600; n++) begin
      wen = ($urandom_range(0, 99) < 30);
      addr = alist[$urandom_range(0, 8)];
      wdata = $urandom;
      if (addr == 8'h48 && $urandom_range(0, 1) == 1)
        wdata = m_cmp - 32'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0)
        ext_int = ext_int ^ 6'(1 << $urandom_range(0, 5));
      exc_valid = ($urandom_range(0, 99) < 8);
      exc_eret = ($urandom_range(0, 2) == 0);
      exc_bd = 1'($urandom_range(0, 1));
      exc_excode = ($urandom_range(0, 3) == 0) ?
        5'(4 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
      exc_epc = $urandom;
      exc_badvaddr = $urandom;
      #1;
      checks++;
      if (rdata !== e_rd(addr)) begin
        errors++;
        $display("FAIL rnd_rdata n=%0d a=%h got=%h exp=%h", n, addr, rdata, e_rd(addr));
      end
      cyc();
      checks++;
      if (status !== e_status()) begin
        errors++; $display("FAIL rnd_status n=%0d got=%h exp=%h", n, status, e_status());
      end
      checks++;
      if (cause !== e_cause()) begin
        errors++; $display("FAIL rnd_cause n=%0d got=%h exp=%h", n, cause, e_cause());
      end
      checks++;
      if (epc !== m_epc) begin
        errors++; $display("FAIL rnd_epc n=%0d got=%h exp=%h", n, epc, m_epc);
      end
      checks++;
      if (int_req !== e_int()) begin
        errors++; $display("FAIL rnd_int n=%0d got=%b exp=%b", n, int_req, e_int());
      end
    end
    idle();
    ext_int = '0;
  endtask

  task automatic test_reset_mid();
    exc_valid = 1'b1; exc_eret = 1'b1;
    cyc();
    idle();
    wr(8'h68, 32'h0);
    wr(8'h60, 32'h0000_0401);
    wr(8'h58, 32'h100);
    wr(8'h48, 32'hFF);
    ext_int[0] = 1'b1;
    cyc();
    ext_int[0] = 1'b0;
    repeat (5) cyc();
    checks++;
    if (cause[30] !== 1'b1 || cause[10] !== 1'b1 || int_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got=%b/%b/%b exp=1/1/1", cause[30], cause[10], int_req);
    end
    ext_int[1] = 1'b1;
    cyc();
    ext_int[1] = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (cause !== 32'h0 || int_req !== 1'b0) begin
      errors++; $display("FAIL mid_async got=%h/%b exp=0/0", cause, int_req);
    end
    checks++;
    if (status !== 32'h0040_0000) begin
      errors++; $display("FAIL mid_status got=%h exp=00400000", status);
    end
    cyc(); cyc();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (cause !== 32'h0 || cause !== e_cause()) begin
        errors++; $display("FAIL mid_after k=%0d got=%h exp=0", k, cause);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timer();
    test_edge_int();
    test_exception();
    test_eret();
    test_same_cycle();
    test_read_old();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cp0_ext.md
CP0_EXT -- requirements
Module: cp0_ext

Interface
REQ-001 SHALL have parameter HW_INT_N, default 6; number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_N-1:2].
REQ-002 SHALL have parameter COUNT_DIV, default 2; clocks per Count increment (1..16).
REQ-003 SHALL have parameter SYNC_STAGES, default 2; flop stages on each ext_int line (0..3; 0 means no synchroniser).
REQ-004 SHALL have parameter INT_EDGE_MASK, default {HW_INT_N{1'b0}}; bit=1 makes that line edge-latched, bit=0 makes it level.
REQ-005 SHALL have parameters PRID, default 32'h0000_4220, and CONFIG, default 32'h8000_0000; read-only constants.
REQ-006 SHALL have clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ext_int  in  HW_INT_N  external interrupt lines.
REQ-009 SHALL have wen, addr[7:0] and wdata[31:0] as inputs: MTC0 write strobe, address {reg[4:0],sel[2:0]}, and write data.
REQ-010 SHALL have rdata  out  32  combinational MFC0 read data.
REQ-011 SHALL have exc_valid, exc_excode[4:0], exc_bd, exc_epc[31:0], exc_badvaddr[31:0] and exc_eret as inputs forming the exception commit bundle.
REQ-012 SHALL have int_req  out  1  interrupt request to the pipeline.
REQ-013 SHALL have status, cause and epc as 32-bit outputs exposing the live register values.

Function
REQ-014 SHALL decode addr as BadVAddr 8'h40, Count 8'h48, Compare 8'h58, Status 8'h60, Cause 8'h68, EPC 8'h70, PRId 8'h78, Config 8'h80; other addresses SHALL read 0 and ignore writes.
REQ-015 SHALL return the register value in the same cycle as addr; a read in the same cycle as a write SHALL return the old value.
REQ-016 Status SHALL be {9'b0, Bev[22], 6'b0, IM[15:8], 6'b0, EXL[1], IE[0]}; Bev, IM, EXL and IE SHALL be writable; all other bits SHALL read 0.
REQ-017 Cause SHALL be {BD[31], TI[30], 14'b0, IP[15:8], 1'b0, ExcCode[6:2], 2'b0}; only IP[9:8] SHALL be directly writable.
REQ-018 SHALL run a prescaler modulo COUNT_DIV that increments Count by 1 on wrap, wrapping 32'hFFFF_FFFF to 0; a Count write SHALL load wdata and clear the prescaler.
REQ-019 TI SHALL set on the cycle Count increments to a value equal to Compare; a Compare write SHALL clear TI, and the clear SHALL win if simultaneous with a set.
REQ-020 A level line's IP bit SHALL follow the synchronised input one cycle after sync output.
REQ-021 An edge line SHALL latch IP on the 0->1 transition of the synchronised input and hold it until a Cause write with that IP bit 0; a set SHALL win over a simultaneous clear.
REQ-022 IP[7] SHALL be TI OR'd with line 5 when HW_INT_N=6; IP bits above line HW_INT_N-1 (except IP[7]) SHALL read 0.
REQ-023 int_req SHALL be |(IP & IM) & IE & ~EXL, computed from registered state with no added latency.
REQ-024 On exc_valid & ~exc_eret, EXL SHALL become 1; if EXL was 0, EPC, BD and ExcCode SHALL load exc_epc, exc_bd and exc_excode.
REQ-025 A nested exception (EXL=1) SHALL leave EPC, BD and ExcCode unchanged.
REQ-026 BadVAddr SHALL load exc_badvaddr when exc_valid and exc_excode is 5'h04 or 5'h05, regardless of EXL.
REQ-027 On exc_valid & exc_eret, EXL SHALL clear and no other register SHALL change.
REQ-028 exc_valid SHALL take priority over a same-cycle MTC0 write to Status.EXL or EPC; the non-conflicting bits of the write SHALL still apply.

Reset
REQ-029 Reset assertion SHALL immediately set status=32'h0040_0000, cause=0, epc=0, Count=0, Compare=0, BadVAddr=0, prescaler=0, all sync and edge flops 0; int_req SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL abort any pending edge latch or TI; no exception or write SHALL be taken while reset is high.

Verification
REQ-031 COUNT_DIV=2: write Count=5, Compare=8 -> TI=1 and cause[30]=1 six cycles after the increment sequence starts; Compare write -> TI=0 next cycle.
REQ-032 Status=32'h0000_0401, INT_EDGE_MASK[0]=1: pulse ext_int[0] for 1 cycle -> int_req=1 after SYNC_STAGES+1 cycles and stays 1; write Cause=0 -> int_req=0.
REQ-033 exc_valid, excode=5'h04, epc=32'hBFC0_0100, badvaddr=32'h0000_0003 -> EXL=1, EPC=32'hBFC0_0100, ExcCode=4, BadVAddr=3; second exc (excode 5'h0C) -> EPC unchanged.
REQ-034 exc_eret with EXL=1 -> EXL=0 and pending unmasked interrupt raises int_req the same cycle EXL clears.
REQ-035 Same-cycle MTC0 Status=0 and exc_valid -> EXL=1, IE=0.
REQ-036 Reset asserted with TI=1 and edge IP latched -> cause=0 and int_req=0 without waiting for a clock edge.
